// File: rtl/alarm_setter.sv
// alarm_setter
//   Front-panel editor for the two BCD alarm registers (HH:MM) and the alarm
//   enable. Raw buttons are synchronized and edge-detected. A small FSM then
//   walks the four editable fields and edits shadow copies. The shadows are
//   copied into alarm1/alarm2 together on the final mode press, so the
//   comparator never sees a half-edited alarm.
//
// Optional build macro: ALARM_SETTER_AUTOREPEAT_EN
//   When defined, holding inc or dec produces repeated steps.
//
// Ports
//   clk         in   1   system clock (1 Hz), rising edge
//   reset       in   1   asynchronous, active-high reset
//   btn_mode    in   1   raw: enter edit / advance field / commit
//   btn_inc     in   1   raw: increment current field
//   btn_dec     in   1   raw: decrement current field
//   btn_cancel  in   1   raw: abandon edit
//   btn_en      in   1   raw: toggle alarm_en (IDLE only)
//   alarm1      out  16  committed alarm1, BCD HHMM
//   alarm2      out  16  committed alarm2, BCD HHMM
//   alarm_en    out  1   alarm enable
//   editing     out  1   high in any edit state
//   edit_field  out  2   0=A1 hour, 1=A1 min, 2=A2 hour, 3=A2 min
//   edit_value  out  8   BCD value of the field being edited
//
// State  | meaning
// IDLE   | not editing, committed values shown to the comparator
// A1H    | editing alarm1 hours
// A1M    | editing alarm1 minutes
// A2H    | editing alarm2 hours
// A2M    | editing alarm2 minutes; mode press commits
module alarm_setter #(
    parameter logic [15:0] A1_RESET       = 16'h0700,
    parameter logic [15:0] A2_RESET       = 16'h0730,
    parameter int unsigned TIMEOUT_CYCLES = 30,
    parameter int unsigned REPEAT_DELAY   = 3,
    parameter int unsigned REPEAT_RATE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_cancel,
    input  logic        btn_en,
    output logic [15:0] alarm1,
    output logic [15:0] alarm2,
    output logic        alarm_en,
    output logic        editing,
    output logic [1:0]  edit_field,
    output logic [7:0]  edit_value
);

    typedef enum logic [2:0] {ST_IDLE, ST_A1H, ST_A1M, ST_A2H, ST_A2M} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Button vector bit order: 0 mode, 1 inc, 2 dec, 3 cancel, 4 en
    logic [4:0]    raw, sync1_q, sync2_q, prev_q, press;
    state_t        state_q, state_d;
    logic [15:0]   s1_q, s1_d, s2_q, s2_d;
    logic [15:0]   a1_q, a1_d, a2_q, a2_d;
    logic          en_q, en_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rep_inc, rep_dec;
    logic          step_up, step_dn, any_press;

    assign raw   = {btn_en, btn_cancel, btn_dec, btn_inc, btn_mode};
    assign press = sync2_q & ~prev_q;

    // Step a BCD field by one, wrapping modulo 'modulus' (24 or 60).
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [6:0] modulus);
        logic [6:0] b;
        b = 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
        if (up) b = (b >= modulus - 7'd1) ? 7'd0 : b + 7'd1;
        else    b = (b == 7'd0 || b >= modulus) ? modulus - 7'd1 : b - 7'd1;
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction

`ifdef ALARM_SETTER_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY + 1 > REPEAT_RATE) ? REPEAT_DELAY + 1
                                                                      : REPEAT_RATE;
    localparam int RW = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_lim;
    logic          rep_run_q, rep_run_d, rep_held, rep_fire;

    // The counter is 0 in the cycle carrying the edge press, so the first
    // repeat lands REPEAT_DELAY+1 cycles after it; later ones every REPEAT_RATE.
    assign rep_held = sync2_q[1] ^ sync2_q[2];
    assign rep_lim  = rep_run_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY + 1);
    assign rep_fire = rep_held && (rep_cnt_q == rep_lim);
    assign rep_inc  = rep_fire & sync2_q[1];
    assign rep_dec  = rep_fire & sync2_q[2];

    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        rep_run_d = rep_run_q;
        if (!rep_held) begin
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
        end else if (rep_fire) begin
            rep_cnt_d = RW'(1);
            rep_run_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q <= '0;
            rep_run_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
        end
    end
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        en_d      = en_q;
        tmo_d     = '0;
        step_up   = press[1] | rep_inc;
        step_dn   = press[2] | rep_dec;
        any_press = (|press) | rep_inc | rep_dec;

        if (state_q == ST_IDLE) begin
            if (press[4]) en_d = ~en_q;
            if (!press[3] && press[0]) begin
                s1_d    = a1_q;
                s2_d    = a2_q;
                state_d = ST_A1H;
            end
        end else begin
            tmo_d = any_press ? '0 : tmo_q + 1'b1;
            if (press[3]) begin
                state_d = ST_IDLE;
            end else if (press[0]) begin
                case (state_q)
                    ST_A1H:  state_d = ST_A1M;
                    ST_A1M:  state_d = ST_A2H;
                    ST_A2H:  state_d = ST_A2M;
                    default: begin
                        a1_d    = s1_q;
                        a2_d    = s2_q;
                        state_d = ST_IDLE;
                    end
                endcase
            end else if (!any_press && tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
            end else if (step_up ^ step_dn) begin
                case (state_q)
                    ST_A1H:  s1_d[15:8] = bcd_step(s1_q[15:8], step_up, 7'd24);
                    ST_A1M:  s1_d[7:0]  = bcd_step(s1_q[7:0],  step_up, 7'd60);
                    ST_A2H:  s2_d[15:8] = bcd_step(s2_q[15:8], step_up, 7'd24);
                    default: s2_d[7:0]  = bcd_step(s2_q[7:0],  step_up, 7'd60);
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            state_q <= ST_IDLE;
            s1_q    <= A1_RESET;
            s2_q    <= A2_RESET;
            a1_q    <= A1_RESET;
            a2_q    <= A2_RESET;
            en_q    <= 1'b1;
            tmo_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            en_q    <= en_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        editing    = (state_q != ST_IDLE);
        edit_field = 2'd0;
        edit_value = 8'h00;
        case (state_q)
            ST_A1H: begin edit_field = 2'd0; edit_value = s1_q[15:8]; end
            ST_A1M: begin edit_field = 2'd1; edit_value = s1_q[7:0];  end
            ST_A2H: begin edit_field = 2'd2; edit_value = s2_q[15:8]; end
            ST_A2M: begin edit_field = 2'd3; edit_value = s2_q[7:0];  end
            default: ;
        endcase
    end

    assign alarm1   = a1_q;
    assign alarm2   = a2_q;
    assign alarm_en = en_q;

endmodule

// File: tb/tb_alarm_setter.sv
module tb_alarm_setter;

    localparam int TIMEOUT = 30;
    localparam int RDELAY  = 3;
    localparam int RRATE   = 1;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MODE = 5'b00001;
    localparam logic [4:0] B_INC  = 5'b00010;
    localparam logic [4:0] B_DEC  = 5'b00100;
    localparam logic [4:0] B_CAN  = 5'b01000;
    localparam logic [4:0] B_EN   = 5'b10000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0, btn_en = 1'b0;
    logic [15:0] alarm1, alarm2;
    logic        alarm_en, editing;
    logic [1:0]  edit_field;
    logic [7:0]  edit_value;
    logic [15:0] o_alarm1, o_alarm2;
    logic        o_en, o_editing;
    logic [1:0]  o_field;
    logic [7:0]  o_value;

    alarm_setter dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_cancel(btn_cancel), .btn_en(btn_en),
        .alarm1(alarm1), .alarm2(alarm2), .alarm_en(alarm_en),
        .editing(editing), .edit_field(edit_field), .edit_value(edit_value)
    );

    alarm_setter #(.A1_RESET(16'h1234), .A2_RESET(16'h2359)) dut_ovr (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_cancel(btn_cancel), .btn_en(btn_en),
        .alarm1(o_alarm1), .alarm2(o_alarm2), .alarm_en(o_en),
        .editing(o_editing), .edit_field(o_field), .edit_value(o_value)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fields held as plain integers (hours 0..23, minutes
    // 0..59), m_state 0 = not editing, 1..4 = editing field m_state-1.
    int         m_state;
    int         sh[4];
    int         cm[4];
    bit         men;
    int         idle_cnt;
    int         hold_c;
    logic [4:0] hist[3];   // raw samples of the last three edges, newest first

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int mod_of(input int f);
        return (f % 2 == 0) ? 24 : 60;
    endfunction

    task automatic model_reset();
        m_state = 0;
        cm[0] = 7; cm[1] = 0; cm[2] = 7; cm[3] = 30;
        for (int i = 0; i < 4; i++) sh[i] = cm[i];
        men = 1'b1;
        idle_cnt = 0;
        hold_c = 0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    task automatic model_step(input logic [4:0] b);
        logic [4:0] lvl, pr;
        bit fire, up, dn, any;
        int f;
        if (reset) begin
            model_reset();
            return;
        end
        // A raw sample takes two edges to reach the synchronized level.
        lvl  = hist[1];
        pr   = hist[1] & ~hist[2];
        fire = 1'b0;
`ifdef ALARM_SETTER_AUTOREPEAT_EN
        if (lvl[1] ^ lvl[2]) begin
            hold_c++;
            fire = (hold_c == RDELAY + 2) ||
                   (hold_c > RDELAY + 2 && (hold_c - RDELAY - 2) % RRATE == 0);
        end else begin
            hold_c = 0;
        end
`endif
        up  = pr[1] | (fire & lvl[1]);
        dn  = pr[2] | (fire & lvl[2]);
        any = (|pr) | fire;
        if (m_state == 0) begin
            idle_cnt = 0;
            if (pr[4]) men = ~men;
            if (!pr[3] && pr[0]) begin
                for (int i = 0; i < 4; i++) sh[i] = cm[i];
                m_state = 1;
            end
        end else begin
            f = m_state - 1;
            if (pr[3]) m_state = 0;
            else if (pr[0]) begin
                if (m_state == 4) begin
                    for (int i = 0; i < 4; i++) cm[i] = sh[i];
                    m_state = 0;
                end else m_state++;
            end else if (!any && idle_cnt + 1 == TIMEOUT) m_state = 0;
            else if (up ^ dn) begin
                if (up) sh[f] = (sh[f] + 1) % mod_of(f);
                else    sh[f] = (sh[f] + mod_of(f) - 1) % mod_of(f);
            end
            idle_cnt = any ? 0 : idle_cnt + 1;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = b;
    endtask

    task automatic check_model();
        chk("m_alarm1", alarm1, 16'(to_bcd(cm[0]) * 256 + to_bcd(cm[1])));
        chk("m_alarm2", alarm2, 16'(to_bcd(cm[2]) * 256 + to_bcd(cm[3])));
        chk("m_alarm_en", 16'(alarm_en), 16'(men));
        chk("m_editing", 16'(editing), 16'(m_state != 0));
        chk("m_edit_field", 16'(edit_field), 16'(m_state == 0 ? 0 : m_state - 1));
        chk("m_edit_value", 16'(edit_value), 16'(m_state == 0 ? 0 : to_bcd(sh[m_state - 1])));
    endtask

    task automatic cycle(input logic [4:0] b);
        {btn_en, btn_cancel, btn_dec, btn_inc, btn_mode} = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        check_model();
    endtask

    task automatic press(input logic [4:0] b);
        cycle(b);
        repeat (3) cycle(B_NONE);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        cycle(B_NONE);
        cycle(B_NONE);
        reset = 1'b0;
        cycle(B_NONE);
    endtask

    typedef struct {
        logic [4:0]  btn;
        logic        editing;
        logic [1:0]  field;
        logic [7:0]  value;
        logic [15:0] a1;
        logic [15:0] a2;
    } vec_t;

    vec_t tbl[10];
    logic [7:0] exp_hold;
    logic [4:0] rb;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{B_MODE, 1'b1, 2'd0, 8'h07, 16'h0700, 16'h0730};
        tbl[1] = '{B_INC,  1'b1, 2'd0, 8'h08, 16'h0700, 16'h0730};
        tbl[2] = '{B_INC,  1'b1, 2'd0, 8'h09, 16'h0700, 16'h0730};
        tbl[3] = '{B_INC,  1'b1, 2'd0, 8'h10, 16'h0700, 16'h0730};
        tbl[4] = '{B_MODE, 1'b1, 2'd1, 8'h00, 16'h0700, 16'h0730};
        tbl[5] = '{B_DEC,  1'b1, 2'd1, 8'h59, 16'h0700, 16'h0730};
        tbl[6] = '{B_DEC,  1'b1, 2'd1, 8'h58, 16'h0700, 16'h0730};
        tbl[7] = '{B_MODE, 1'b1, 2'd2, 8'h07, 16'h0700, 16'h0730};
        tbl[8] = '{B_MODE, 1'b1, 2'd3, 8'h30, 16'h0700, 16'h0730};
        tbl[9] = '{B_MODE, 1'b0, 2'd0, 8'h00, 16'h1058, 16'h0730};

        // Reset values, default and overridden
        do_reset();
        chk("rst_alarm1", alarm1, 16'h0700);
        chk("rst_alarm2", alarm2, 16'h0730);
        chk("rst_alarm_en", 16'(alarm_en), 16'h1);
        chk("rst_editing", 16'(editing), 16'h0);
        chk("ovr_alarm1", o_alarm1, 16'h1234);
        chk("ovr_alarm2", o_alarm2, 16'h2359);

        // Full edit and commit
        for (int i = 0; i < 10; i++) begin
            press(tbl[i].btn);
            chk("tbl_editing", 16'(editing), 16'(tbl[i].editing));
            chk("tbl_field", 16'(edit_field), 16'(tbl[i].field));
            chk("tbl_value", 16'(edit_value), 16'(tbl[i].value));
            chk("tbl_alarm1", alarm1, tbl[i].a1);
            chk("tbl_alarm2", alarm2, tbl[i].a2);
        end

        // Hour wrap then cancel
        do_reset();
        press(B_MODE);
        repeat (17) press(B_INC);
        chk("wrap_value", 16'(edit_value), 16'h00);
        press(B_CAN);
        chk("cancel_editing", 16'(editing), 16'h0);
        chk("cancel_alarm1", alarm1, 16'h0700);
        press(B_MODE);
        chk("reentry_value", 16'(edit_value), 16'h07);
        press(B_CAN);

        // Timeout, then timeout restarted by a press at count 29
        cycle(B_MODE);
        for (int k = 2; k <= 32; k++) cycle(B_NONE);
        chk("tmo_before", 16'(editing), 16'h1);
        cycle(B_NONE);
        chk("tmo_after", 16'(editing), 16'h0);
        chk("tmo_alarm1", alarm1, 16'h0700);
        cycle(B_MODE);
        for (int k = 2; k <= 30; k++) cycle(B_NONE);
        cycle(B_INC);
        for (int k = 32; k <= 62; k++) cycle(B_NONE);
        chk("tmo_restart_before", 16'(editing), 16'h1);
        chk("tmo_restart_value", 16'(edit_value), 16'h08);
        cycle(B_NONE);
        chk("tmo_restart_after", 16'(editing), 16'h0);

        // Held inc in A1M
`ifdef ALARM_SETTER_AUTOREPEAT_EN
        exp_hold = 8'h07;
`else
        exp_hold = 8'h01;
`endif
        do_reset();
        press(B_MODE);
        press(B_MODE);
        repeat (10) cycle(B_INC);
        repeat (4) cycle(B_NONE);
        chk("hold_value", 16'(edit_value), 16'(exp_hold));

        // Enable toggle, ignored while editing, reset mid-edit
        do_reset();
        press(B_EN);
        chk("en_idle", 16'(alarm_en), 16'h0);
        repeat (3) press(B_MODE);
        chk("en_field_a2h", 16'(edit_field), 16'h2);
        press(B_EN);
        chk("en_in_edit", 16'(alarm_en), 16'h0);
        press(B_INC);
        press(B_MODE);
        chk("mid_field", 16'(edit_field), 16'h3);
        reset = 1'b1;
        #1;
        chk("mid_rst_alarm1", alarm1, 16'h0700);
        chk("mid_rst_alarm2", alarm2, 16'h0730);
        chk("mid_rst_en", 16'(alarm_en), 16'h1);
        chk("mid_rst_editing", 16'(editing), 16'h0);
        chk("mid_rst_field", 16'(edit_field), 16'h0);
        chk("mid_rst_value", 16'(edit_value), 16'h00);
        model_reset();
        cycle(B_NONE);
        reset = 1'b0;
        cycle(B_NONE);

        // Random button activity against the model
        rb = B_NONE;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, (k == 3) ? 60 : 6) == 0) rb[k] = ~rb[k];
            end
            cycle(rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_setter.md
# alarm_setter

Button-driven editor that writes the two BCD alarm registers (HH:MM) and the alarm enable consumed by the alarm comparator. Synchronizes and edge-detects user buttons, steps through the four editable fields with a state machine, and edits shadow copies. Commits the shadow copies atomically on completion, so the comparator never sees a half-edited alarm. Sits between the front-panel buttons and the alarm block, clocked by the same 1 Hz `clk` as the time counter.

## Interface
- `A1_RESET`, 16'h0700, alarm1 value after reset (BCD HHMM).
- `A2_RESET`, 16'h0730, alarm2 value after reset (BCD HHMM).
- `TIMEOUT_CYCLES`, 30, idle cycles in an edit state before the edit is abandoned (≥2).
- `REPEAT_DELAY`, 3, hold cycles before the first auto-repeat step (≥2).
- `REPEAT_RATE`, 1, cycles between later auto-repeat steps (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_mode`  in  1  raw button: enter edit, or advance to the next field.
- `btn_inc`  in  1  raw button: increment the current field.
- `btn_dec`  in  1  raw button: decrement the current field.
- `btn_cancel`  in  1  raw button: abandon the edit.
- `btn_en`  in  1  raw button: toggle `alarm_en` (IDLE only).
- `alarm1`  out  16  committed alarm1: [15:12] hour tens, [11:8] hour units, [7:4] minute tens, [3:0] minute units.
- `alarm2`  out  16  committed alarm2, same format.
- `alarm_en`  out  1  alarm enable.
- `editing`  out  1  high in any edit state.
- `edit_field`  out  2  0=A1 hour, 1=A1 min, 2=A2 hour, 3=A2 min; 0 when not editing.
- `edit_value`  out  8  BCD value of the field being edited; 8'h00 when not editing.

## Operation
- Each `btn_*` input goes through a 2-flop synchronizer, then a rising-edge detector, which produces a one-cycle press pulse.
- States: IDLE, A1H, A1M, A2H, A2M.
- Entering edit: mode press in IDLE loads shadow registers s1/s2 from `alarm1`/`alarm2` and moves to A1H.
- Mode press advances A1H→A1M→A2H→A2M.
- Mode press in A2M commits: `alarm1`←s1, `alarm2`←s2, next state IDLE.
- Cancel press, or timeout, in any edit state: go to IDLE and discard the shadow registers; committed outputs are unchanged.
- Inc/dec act only on the current field of the shadow registers.
  - Hours wrap 23→00 on inc and 00→23 on dec.
  - Minutes wrap 59→00 on inc and 00→59 on dec.
  - Results are always valid BCD.
- Priority within one cycle: cancel > mode > inc/dec. Inc and dec pressed together: no change.
- `btn_en` press in IDLE toggles `alarm_en`. Ignored in edit states.
- Inc/dec presses in IDLE are ignored.
- Timeout counter:
  - cleared on entering any edit state and on any press;
  - increments every cycle otherwise;
  - reaching `TIMEOUT_CYCLES` forces IDLE.
- Reset values: `alarm1`=A1_RESET, `alarm2`=A2_RESET, `alarm_en`=1, `editing`=0, `edit_field`=0, `edit_value`=8'h00, state IDLE, synchronizers 0.
- Reset asserted mid-edit discards the edit. Outputs return to the reset values.

## Timing
- A raw input first sampled high at rising edge N gives a press pulse during cycle N+1..N+2. Its effect is registered at edge N+2, so the 2-cycle latency is visible after N+2.
- A held button gives exactly one press. A new press needs the synchronized input low for ≥1 cycle.
- `alarm1`/`alarm2` change only on the commit edge, and both update on that same edge.
- `edit_field`, `edit_value` and `editing` are registered or derived from registered state. They reflect the state after each edge.
- Timeout: with no presses, IDLE is entered at the edge where the counter reaches `TIMEOUT_CYCLES`, counted from the state entry or the last press.

## Configuration
- `ALARM_SETTER_AUTOREPEAT_EN` defined:
  - Holding inc or dec (synchronized level high, and not both together) generates a step after `REPEAT_DELAY` cycles, then one every `REPEAT_RATE` cycles.
  - Each repeat step counts as a press for the timeout counter.
- Undefined: only edges produce steps. The repeat counters are not built.

## Test plan
- Reset -> `alarm1`=16'h0700, `alarm2`=16'h0730, `alarm_en`=1, `editing`=0. Outputs follow A1_RESET/A2_RESET overrides.
- mode, 3×inc, mode, 2×dec, mode, mode, mode -> `alarm1`=16'h1058, `alarm2`=16'h0730. `editing` drops on the last mode press.
- Enter edit, 17×inc on A1H (07→00 wrap), then cancel -> `alarm1` stays 16'h0700. A second entry shows `edit_value`=8'h07.
- Enter edit, then no presses -> back to IDLE exactly 30 cycles later, outputs unchanged. A press at cycle 29 restarts the count.
- Hold inc for 10 cycles in A1M:
  - macro defined: `edit_value` 00→07, i.e. 1 edge press plus repeats from cycle 3 (REPEAT_DELAY=3, REPEAT_RATE=1);
  - macro undefined: `edit_value`=01.
- `btn_en` pressed in IDLE -> `alarm_en`=0. Pressed in A2H -> no change. Reset asserted mid-edit in A2M -> all outputs at reset values immediately.
